// File: rtl/led_lane_reorder.sv
// Lane reorder (pass / lane reverse / lane rotate / per-lane bit reverse) into a 2-entry output buffer.
// One cycle latency with no bypass; in_ready depends only on the registered fill count.
module led_lane_reorder #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int ROT_W  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANE_W*LANES-1:0]  in_data,
  input  logic [1:0]               in_mode,
  input  logic [ROT_W-1:0]         in_rot,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [LANE_W*LANES-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         beat_cnt
);

  localparam int W = LANE_W * LANES;

  logic [W-1:0] xf;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  always_comb begin
    xf = '0;
    for (int k = 0; k < LANES; k++) begin
      case (in_mode)
        2'd0: xf[k*LANE_W +: LANE_W] = in_data[k*LANE_W +: LANE_W];
        2'd1: xf[k*LANE_W +: LANE_W] = in_data[(LANES-1-k)*LANE_W +: LANE_W];
        // Rotate amount may exceed LANES-1 when LANES is not a power of two.
        2'd2: xf[k*LANE_W +: LANE_W] = in_data[((k + int'(in_rot)) % LANES)*LANE_W +: LANE_W];
        default: begin
          for (int j = 0; j < LANE_W; j++)
            xf[k*LANE_W + j] = in_data[k*LANE_W + LANE_W - 1 - j];
        end
      endcase
    end
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // head_q is the visible entry and keeps the last popped word once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      beat_cnt <= '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= xf;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= xf;
          end else if (push) begin
            tail_q  <= xf;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
      endcase
      if (pop)
        beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_led_lane_reorder.sv
// Directed bench: default 8x2 instance for swap/backpressure/stream/reset,
// 4x4 instance with a 4-bit counter for transform modes and counter wrap.
module tb_led_lane_reorder;

  logic clk;
  logic rst_n;

  logic [15:0] a_in_data;
  logic [1:0]  a_in_mode;
  logic [0:0]  a_in_rot;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [15:0] a_beat_cnt;

  logic [15:0] b_in_data;
  logic [1:0]  b_in_mode;
  logic [1:0]  b_in_rot;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [3:0]  b_beat_cnt;

  int nchk = 0;
  int nerr = 0;

  led_lane_reorder u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_mode(a_in_mode), .in_rot(a_in_rot),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .beat_cnt(a_beat_cnt)
  );

  led_lane_reorder #(.LANE_W(4), .LANES(4), .ROT_W(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_mode(b_in_mode), .in_rot(b_in_rot),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .beat_cnt(b_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One isolated beat through instance b: visible the cycle after push, popped the next edge.
  task automatic b_beat(input string tag, input logic [15:0] d, input logic [1:0] m,
                        input logic [1:0] r, input logic [15:0] exp);
    b_in_data  = d;
    b_in_mode  = m;
    b_in_rot   = r;
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk({tag, "_vld"}, {31'd0, b_out_valid}, 32'd1);
    chk(tag, {16'd0, b_out_data}, {16'd0, exp});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int rcv;
    int bubbles;
    bit started;

    rst_n = 1'b0;
    a_in_data = '0; a_in_mode = '0; a_in_rot = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_mode = '0; b_in_rot = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();

    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, a_out_data}, 32'd0);
    chk("rst_beat_cnt", {16'd0, a_beat_cnt}, 32'd0);
    chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Byte swap on the default configuration.
    a_in_data = 16'hA55A; a_in_mode = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("swap_vld", {31'd0, a_out_valid}, 32'd1);
    chk("swap_data", {16'd0, a_out_data}, 32'h5AA5);
    tick();
    chk("swap_vld_drop", {31'd0, a_out_valid}, 32'd0);
    chk("swap_cnt", {16'd0, a_beat_cnt}, 32'd1);
    chk("swap_hold_last", {16'd0, a_out_data}, 32'h5AA5);

    // 4x4 transforms.
    b_beat("rot1", 16'h1234, 2'd2, 2'd1, 16'h4123);
    b_beat("pass", 16'h1234, 2'd0, 2'd0, 16'h1234);
    b_beat("rev", 16'h1234, 2'd1, 2'd0, 16'h4321);
    b_beat("bitrev", 16'h1234, 2'd3, 2'd0, 16'h84C2);
    b_beat("rot3", 16'h1234, 2'd2, 2'd3, 16'h2341);
    chk("b_cnt5", {28'd0, b_beat_cnt}, 32'd5);

    // Counter wrap: 17 deliveries in total on a 4-bit counter.
    for (int i = 0; i < 11; i++)
      b_beat("wrap_beat", 16'(i), 2'd0, 2'd0, 16'(i));
    chk("wrap_cnt16", {28'd0, b_beat_cnt}, 32'd0);
    b_beat("wrap_beat", 16'h00AA, 2'd0, 2'd0, 16'h00AA);
    chk("wrap_cnt17", {28'd0, b_beat_cnt}, 32'd1);

    // Backpressure: third beat must be held by the source until space frees.
    a_in_mode = 2'd0; a_out_ready = 1'b0;
    a_in_data = 16'h0001; a_in_valid = 1'b1;
    tick();
    chk("bp_rdy_1", {31'd0, a_in_ready}, 32'd1);
    a_in_data = 16'h0002;
    tick();
    chk("bp_rdy_full", {31'd0, a_in_ready}, 32'd0);
    chk("bp_head", {16'd0, a_out_data}, 32'h0001);
    a_in_data = 16'h0003;
    tick();
    chk("bp_rdy_held", {31'd0, a_in_ready}, 32'd0);
    chk("bp_head_held", {16'd0, a_out_data}, 32'h0001);
    a_out_ready = 1'b1;
    tick();
    chk("bp_out2", {16'd0, a_out_data}, 32'h0002);
    chk("bp_rdy_after_pop", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("bp_out3", {16'd0, a_out_data}, 32'h0003);
    chk("bp_vld3", {31'd0, a_out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, a_out_valid}, 32'd0);
    chk("bp_cnt", {16'd0, a_beat_cnt}, 32'd4);

    // Streaming 100 beats from a fresh reset.
    reset_pulse();
    a_in_mode = 2'd0; a_out_ready = 1'b1;
    sent = 0; rcv = 0; bubbles = 0; started = 1'b0;
    for (int cyc = 0; cyc < 400 && rcv < 100; cyc++) begin
      a_in_valid = (sent < 100);
      a_in_data  = 16'h0100 + 16'(sent);
      if (a_out_valid) begin
        started = 1'b1;
        chk("stream_data", {16'd0, a_out_data}, {16'd0, 16'h0100 + 16'(rcv)});
        rcv++;
      end else if (started) begin
        bubbles++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick();
    end
    a_in_valid = 1'b0;
    chk("stream_rcv", rcv, 100);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_cnt", {16'd0, a_beat_cnt}, 32'd100);

    // Asynchronous reset while full.
    a_out_ready = 1'b0;
    a_in_data = 16'h1111; a_in_valid = 1'b1;
    tick();
    a_in_data = 16'h2222;
    tick();
    a_in_valid = 1'b0;
    chk("mid_full", {31'd0, a_in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, a_out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, a_in_ready}, 32'd1);
    chk("mid_rst_cnt", {16'd0, a_beat_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    a_in_data = 16'hBEEF; a_in_mode = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("post_rst_data", {16'd0, a_out_data}, 32'hBEEF);
    chk("post_rst_vld", {31'd0, a_out_valid}, 32'd1);
    tick();
    chk("post_rst_cnt", {16'd0, a_beat_cnt}, 32'd1);
    chk("post_rst_empty", {31'd0, a_out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/led_lane_reorder.md
Name: led_lane_reorder

Overview:
- Parametrised, registered lane-reordering stage for LED/display data paths.
- Splits an input word into LANES lanes of LANE_W bits and applies a per-beat selectable reorder: pass, lane reverse, lane rotate, or bit-reverse within each lane.
- With LANE_W=8, LANES=2 and mode 1 it performs the 16-bit byte swap used in current LED correction.
- Adds a valid/ready handshake with a 2-entry output buffer, so it can sit between a pixel/segment source and a shift-out driver that stalls.

Parameters:
- LANE_W, 8, bits per lane.
- LANES, 2, number of lanes. Legal range 2..16.
- ROT_W, 1, width of the rotate amount. Must be max(1, clog2(LANES)).
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  LANE_W*LANES  input word; lane k is bits [k*LANE_W +: LANE_W].
- in_mode  in  2  transform select: 0 pass, 1 reverse lanes, 2 rotate lanes, 3 bit-reverse each lane.
- in_rot  in  ROT_W  rotate amount for mode 2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  LANE_W*LANES  transformed word at the buffer head.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the beat.
- beat_cnt  out  CNT_W  number of beats delivered since reset; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: buffer count=0, out_valid=0, out_data=0, beat_cnt=0, in_ready=1. Both buffer entries clear to 0.
- Reset mid-operation:
  - Any buffered beats are discarded.
  - in_ready=1 takes effect immediately on assertion.
  - The first accepted beat after reset release is the next one seen at a clk edge with rst_n=1.
- Transform: purely combinational on in_data, in_mode and in_rot, evaluated in the cycle the beat is accepted. The result is stored, so later changes to in_mode and in_rot do not affect stored beats.
  - Mode 0: out lane k = in lane k.
  - Mode 1: out lane k = in lane LANES-1-k.
  - Mode 2: out lane k = in lane (k + in_rot) mod LANES. If in_rot >= LANES (non-power-of-2 LANES), the index is still reduced mod LANES.
  - Mode 3: out lane k bit j = in lane k bit LANE_W-1-j.
- Buffer: 2-entry FIFO of transformed words; count ranges 0..2.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = (count != 2), derived from registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0). out_data = head entry; it is held stable while out_valid=1 and out_ready=0.
- Latency: a beat pushed at edge N appears on out_data with out_valid=1 after edge N when the buffer was empty; there is no bypass path.
- Simultaneous push and pop:
  - count=1: count stays 1. The new beat becomes head after the old head leaves; order is preserved.
  - count=2: no push is possible (in_ready=0). The pop brings count to 1 and in_ready=1 in the next cycle.
  - count=0: pop is impossible; push only.
- Full: count=2 holds data indefinitely. in_valid is ignored and the input beat is not lost, because the source holds it.
- Empty: out_data keeps the last popped value (or 0 after reset). out_valid=0.
- beat_cnt increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- Throughput: one beat per cycle sustained when out_ready=1 continuously.

Test Plan:
- Reset, then defaults: in_data=16'hA55A, mode 1, one beat, out_ready=1 -> out_data=16'h5AA5, out_valid high for 1 cycle, beat_cnt=1.
- LANE_W=4, LANES=4: in_data=16'h1234. Mode 2 with rot=1 -> 16'h4123. Mode 0 -> 16'h1234. Mode 1 -> 16'h4321. Mode 3 -> 16'h84C2.
- Backpressure: out_ready=0, push 3 beats (16'h0001, 16'h0002, 16'h0003) -> in_ready low after 2 pushes and the third is held. Release out_ready -> outputs appear in order 0001, 0002, 0003 on consecutive cycles.
- Streaming: in_valid=1 and out_ready=1 for 100 beats with incrementing data in mode 0 -> no bubbles after the first cycle, beat_cnt=100.
- Reset mid-operation: count=2, assert rst_n=0 asynchronously between edges -> out_valid=0 and in_ready=1 immediately. After release, a new beat 16'hBEEF in mode 0 -> out 16'hBEEF, beat_cnt=1.
- Wrap: CNT_W=4, deliver 17 beats -> beat_cnt=1.
